fast_adder32: RTL and testbench
===============================

# fast_adder32

Registered 32-bit two's-complement adder with selectable fast-carry architecture: carry-lookahead (CLA), carry-increment (CIA) or carry-bypass/skip (CBPA). It is the common datapath adder used to compare fast-carry schemes. All three architectures are bit-exact equivalents. The combinational core feeds one output register stage.

## Interface
- ARCH, default 0: carry scheme; 0 = CLA, 1 = CIA, 2 = CBPA. Other values are illegal; elaboration error.
- WIDTH, default 32: operand width; must be a multiple of GROUP.
- GROUP, default 4: bits per carry group (lookahead group, increment block, bypass block).
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operands valid this cycle.
- in1  in  WIDTH  operand A, two's complement.
- in2  in  WIDTH  operand B, two's complement.
- cin  in  1  carry into bit 0.
- out_valid  out  1  sum, cout, overflow hold a new result.
- sum  out  WIDTH  (in1 + in2 + cin) mod 2^WIDTH.
- cout  out  1  carry out of bit WIDTH-1 (unsigned carry).
- overflow  out  1  signed overflow.

## Operation
- Combinational: {cout, sum} = in1 + in2 + cin, zero-extended to WIDTH+1 bits, unsigned.
- overflow = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1. This is equivalent to both operands having the same sign and sum having the opposite sign.
- CLA: per-bit g = a&b and p = a^b. Each GROUP uses lookahead carries. A second-level lookahead computes the group carries from group G/P.
- CIA: each group computes a ripple sum assuming carry-in 0, plus a group propagate. Results are incremented by the incoming group carry. Group carry out = local carry OR (group P AND carry in).
- CBPA: each group ripples internally. Group carry out = group P ? group carry in : ripple carry out (skip mux).
- cin participates identically in all architectures.
- No saturation and no sign extension of sum; cout and overflow are both always reported.

## Timing
- Latency 1 cycle: operands sampled on a rising edge with in_valid=1 appear on sum/cout/overflow after that edge, with out_valid=1.
- in_valid=0 at an edge: out_valid goes to 0. sum, cout and overflow hold their last value.
- Back-to-back in_valid gives one result per cycle. There is no backpressure.
- Reset (rst_n low, at any time, asynchronous): sum=0, cout=0, overflow=0, out_valid=0 immediately. A transaction in flight during reset is discarded.
- First capture occurs on the first rising edge after rst_n deasserts.
- The combinational path must close timing at the target clock. Architecture choice affects only critical path, never results.

## Structure
- Shared package fast_adder_pkg holds:
  - ARCH encodings: ARCH_CLA=0, ARCH_CIA=1, ARCH_CBPA=2.
  - Default WIDTH=32 and GROUP=4.
- One sub-module, adder_group: a GROUP-bit slice with inputs a, b, cin. It outputs sum, carry out, group generate, group propagate and carry into its MSB.
- The top generates WIDTH/GROUP slices and the inter-group carry network selected by ARCH, followed by the output register.

## Test plan
Run every scenario for ARCH = 0, 1 and 2. Check one cycle after the in_valid edge.
- Positive overflow: in1=0x40000000, in2=0x40000000, cin=0 -> sum=0x80000000, cout=0, overflow=1.
- Negative overflow: in1=0x80000001, in2=0x80000001, cin=0 -> sum=0x00000002, cout=1, overflow=1.
- Mixed signs: in1=0x00000001, in2=0x80000000 -> sum=0x80000001, cout=0, overflow=0.
- Negative plus negative, no overflow: in1=in2=0xFFFFFFEA -> sum=0xFFFFFFD4, cout=1, overflow=0.
- Small positives and carry-in:
  - 0xDE + 0xDE -> 0x000001BC, cout=0, overflow=0.
  - 0xFFFFFFFF + 0 with cin=1 -> sum=0, cout=1, overflow=0 (full-length carry propagation/bypass).
- Control:
  - Assert rst_n low mid-stream -> all outputs 0 immediately.
  - in_valid low -> out_valid 0 next edge, sum held.
  - Random operands compared against the reference sum.

Source files
------------

// File: rtl/fast_adder_pkg.sv
// Shared encodings and defaults for the fast-carry adder family.
// Every architecture produces the same result; they differ only in how carries travel between groups.
package fast_adder_pkg;

    localparam int ARCH_CLA  = 0;
    localparam int ARCH_CIA  = 1;
    localparam int ARCH_CBPA = 2;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_GROUP = 4;

    typedef enum logic [1:0] {
        ARCH_E_CLA  = 2'd0,
        ARCH_E_CIA  = 2'd1,
        ARCH_E_CBPA = 2'd2
    } arch_e;

    function automatic bit arch_is_legal(input int arch);
        return (arch == ARCH_CLA) || (arch == ARCH_CIA) || (arch == ARCH_CBPA);
    endfunction

    function automatic bit geometry_is_legal(input int width, input int group);
        return (group > 0) && (width >= group) && ((width % group) == 0);
    endfunction

endpackage

// File: rtl/fast_adder32_adder_group.sv
// One GROUP-bit carry slice. It reports sum, carry out, group generate/propagate
// and the carry into its MSB, with the internal carry style selected by ARCH.
module adder_group
    import fast_adder_pkg::*;
#(
    parameter int GROUP = DEFAULT_GROUP,
    parameter int ARCH  = ARCH_CLA
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             cin,
    output logic [GROUP-1:0] sum,
    output logic             cout,
    output logic             gg,
    output logic             gp,
    output logic             c_msb
);

    logic [GROUP-1:0] g;
    logic [GROUP-1:0] p;
    logic [GROUP-1:0] pre_g;
    logic [GROUP-1:0] pre_p;
    logic [GROUP:0]   c;
    logic [GROUP:0]   c0;
    logic [GROUP-1:0] s0;
    logic [GROUP-1:0] k;
    logic             gacc;
    logic             pacc;

    always_comb begin
        g     = a & b;
        p     = a ^ b;
        pre_g = '0;
        pre_p = '0;
        c     = '0;
        c0    = '0;
        s0    = '0;
        k     = '0;
        sum   = '0;
        cout  = 1'b0;
        gacc  = 1'b0;
        pacc  = 1'b1;

        // Prefix generate/propagate over bits [i:0]; these are independent of cin.
        for (int i = 0; i < GROUP; i++) begin
            gacc     = g[i] | (p[i] & gacc);
            pacc     = pacc & p[i];
            pre_g[i] = gacc;
            pre_p[i] = pacc;
        end
        gg = gacc;
        gp = pacc;

        case (ARCH)
            ARCH_CLA: begin
                c[0] = cin;
                for (int i = 0; i < GROUP; i++) begin
                    c[i+1] = pre_g[i] | (pre_p[i] & cin);
                end
                sum  = p ^ c[GROUP-1:0];
                cout = c[GROUP];
            end
            ARCH_CIA: begin
                // Local sum assumes carry-in 0, then an incrementer folds in cin.
                for (int i = 0; i < GROUP; i++) begin
                    c0[i+1] = pre_g[i];
                end
                s0   = p ^ c0[GROUP-1:0];
                k[0] = cin;
                for (int i = 0; i < GROUP - 1; i++) begin
                    k[i+1] = k[i] & s0[i];
                end
                sum  = s0 ^ k;
                cout = gg | (gp & cin);
                c[0] = cin;
                for (int i = 1; i <= GROUP; i++) begin
                    c[i] = c0[i] | (pre_p[i-1] & cin);
                end
            end
            default: begin
                c[0] = cin;
                for (int i = 0; i < GROUP; i++) begin
                    c[i+1] = g[i] | (p[i] & c[i]);
                end
                sum  = p ^ c[GROUP-1:0];
                // Skip mux: a fully propagating block forwards its carry-in directly.
                cout = gp ? cin : c[GROUP];
            end
        endcase

        c_msb = c[GROUP-1];
    end

endmodule

// File: rtl/fast_adder32.sv
// Registered WIDTH-bit adder with selectable inter-group carry network (CLA, CIA or CBPA).
// One output register stage; out_valid tracks in_valid, data holds when no new operands arrive.
module fast_adder32
    import fast_adder_pkg::*;
#(
    parameter int ARCH  = ARCH_CLA,
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int GROUP = DEFAULT_GROUP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int NG = WIDTH / GROUP;

    if (!arch_is_legal(ARCH)) begin : g_bad_arch
        $error("fast_adder32: ARCH must be 0 (CLA), 1 (CIA) or 2 (CBPA)");
    end
    if (!geometry_is_legal(WIDTH, GROUP)) begin : g_bad_geometry
        $error("fast_adder32: WIDTH must be a positive multiple of GROUP");
    end

    logic [NG-1:0]    grp_g;
    logic [NG-1:0]    grp_p;
    logic [NG-1:0]    grp_cm;
    logic [NG-1:0]    cla_c;
    logic [WIDTH-1:0] sum_c;
    logic             cout_c;
    logic             ovf_c;
    logic             unused_cm;

    // Second-level lookahead: group carries from group G/P only.
    always_comb begin
        cla_c    = '0;
        cla_c[0] = cin;
        for (int k = 1; k < NG; k++) begin
            cla_c[k] = grp_g[k-1] | (grp_p[k-1] & cla_c[k-1]);
        end
    end

    for (genvar gi = 0; gi < NG; gi++) begin : g_grp
        logic             ci;
        logic             co;
        logic [GROUP-1:0] s;

        if (gi == 0) begin : g_first
            assign ci = cla_c[0];
        end else begin : g_rest
            // CIA and CBPA chain through each group's carry-out logic.
            assign ci = (ARCH == ARCH_CLA) ? cla_c[gi] : g_grp[gi-1].co;
        end

        adder_group #(
            .GROUP (GROUP),
            .ARCH  (ARCH)
        ) u_group (
            .a     (in1[gi*GROUP +: GROUP]),
            .b     (in2[gi*GROUP +: GROUP]),
            .cin   (ci),
            .sum   (s),
            .cout  (co),
            .gg    (grp_g[gi]),
            .gp    (grp_p[gi]),
            .c_msb (grp_cm[gi])
        );

        assign sum_c[gi*GROUP +: GROUP] = s;
    end

    assign unused_cm = ^grp_cm;

    always_comb begin
        if (ARCH == ARCH_CLA) begin
            cout_c = grp_g[NG-1] | (grp_p[NG-1] & cla_c[NG-1]);
        end else begin
            cout_c = g_grp[NG-1].co;
        end
        ovf_c = grp_cm[NG-1] ^ cout_c;
    end

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    always_comb begin
        valid_d = in_valid;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        if (in_valid) begin
            sum_d  = sum_c;
            cout_d = cout_c;
            ovf_d  = ovf_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out_valid = valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_fast_adder32.sv
// Directed and random checks of fast_adder32 for all three carry architectures side by side.
module tb_fast_adder32;

    localparam int W = 32;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic [W-1:0]  in1;
    logic [W-1:0]  in2;
    logic          cin;
    logic          valid_o [3];
    logic [W-1:0]  sum_o   [3];
    logic          cout_o  [3];
    logic          ovf_o   [3];

    int n_checks;
    int n_fail;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        fast_adder32 #(
            .ARCH  (gi),
            .WIDTH (32),
            .GROUP (4)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in1       (in1),
            .in2       (in2),
            .cin       (cin),
            .out_valid (valid_o[gi]),
            .sum       (sum_o[gi]),
            .cout      (cout_o[gi]),
            .overflow  (ovf_o[gi])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } vec_t;

    vec_t vecs [12];

    task automatic expect_all(input string tag, input logic v, input logic ov,
                              input logic co, input logic [W-1:0] s);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if ({valid_o[k], ovf_o[k], cout_o[k], sum_o[k]} !== {v, ov, co, s}) begin
                n_fail++;
                $display("FAIL %s arch=%0d: got valid=%b ovf=%b cout=%b sum=%08h, want valid=%b ovf=%b cout=%b sum=%08h",
                         tag, k, valid_o[k], ovf_o[k], cout_o[k], sum_o[k], v, ov, co, s);
            end
        end
    endtask

    task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        @(negedge clk);
        in_valid = v;
        in1      = a;
        in2      = b;
        cin      = c;
    endtask

    logic [W:0]   ref_full;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    logic         rov;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in1      = '0;
        in2      = '0;
        cin      = 1'b0;

        vecs[0]  = '{32'h4000_0000, 32'h4000_0000, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        vecs[1]  = '{32'h8000_0001, 32'h8000_0001, 1'b0, 32'h0000_0002, 1'b1, 1'b1};
        vecs[2]  = '{32'h0000_0001, 32'h8000_0000, 1'b0, 32'h8000_0001, 1'b0, 1'b0};
        vecs[3]  = '{32'hFFFF_FFEA, 32'hFFFF_FFEA, 1'b0, 32'hFFFF_FFD4, 1'b1, 1'b0};
        vecs[4]  = '{32'h0000_00DE, 32'h0000_00DE, 1'b0, 32'h0000_01BC, 1'b0, 1'b0};
        vecs[5]  = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        vecs[6]  = '{32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 32'h8000_0000, 1'b0, 1'b1};
        vecs[7]  = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
        vecs[8]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[9]  = '{32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        vecs[10] = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0};
        vecs[11] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};

        #1;
        expect_all("reset_state", 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].c);
            @(posedge clk);
            #1;
            $display("vec %0d: %08h + %08h + %b -> sum=%08h cout=%b ovf=%b", i,
                     vecs[i].a, vecs[i].b, vecs[i].c, sum_o[0], cout_o[0], ovf_o[0]);
            expect_all($sformatf("vec%0d", i), 1'b1, vecs[i].ov, vecs[i].co, vecs[i].s);
        end

        // in_valid low: out_valid drops, data from the last vector is held.
        drive(1'b0, 32'h1111_1111, 32'h2222_2222, 1'b1);
        @(posedge clk);
        #1;
        $display("idle cycle: out_valid=%b sum=%08h", valid_o[0], sum_o[0]);
        expect_all("idle_hold", 1'b0, 1'b1, 1'b1, 32'h0000_0000);

        drive(1'b1, 32'h0000_00DE, 32'h0000_00DE, 1'b0);
        @(posedge clk);
        #1;
        expect_all("resume", 1'b1, 1'b0, 1'b0, 32'h0000_01BC);

        // Asynchronous reset between edges clears outputs without a clock.
        #2;
        rst_n = 1'b0;
        #1;
        $display("async reset asserted: out_valid=%b sum=%08h", valid_o[0], sum_o[0]);
        expect_all("async_reset", 1'b0, 1'b0, 1'b0, 32'h0);

        // Operands presented while in reset are discarded.
        drive(1'b1, 32'h4000_0000, 32'h4000_0000, 1'b0);
        @(posedge clk);
        #1;
        expect_all("held_in_reset", 1'b0, 1'b0, 1'b0, 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        $display("first capture after reset: sum=%08h", sum_o[0]);
        expect_all("first_after_reset", 1'b1, 1'b1, 1'b0, 32'h8000_0000);

        for (int i = 0; i < 24; i++) begin
            ra = $urandom();
            rb = $urandom();
            rc = 1'(($urandom() >> 3) & 1);
            if (i % 6 == 0) rb = ~ra;
            ref_full = {1'b0, ra} + {1'b0, rb} + {32'b0, rc};
            rov = (ra[W-1] == rb[W-1]) && (ref_full[W-1] != ra[W-1]);
            drive(1'b1, ra, rb, rc);
            @(posedge clk);
            #1;
            $display("rand %0d: %08h + %08h + %b -> sum=%08h", i, ra, rb, rc, sum_o[0]);
            expect_all($sformatf("rand%0d", i), 1'b1, rov, ref_full[W], ref_full[W-1:0]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
